// File: rtl/ychg_scheduler.sv
// Change-list scheduler: buffers (row, col, delta) records, issues them one at a time to the
// Y-update datapath with timeout supervision, and arbitrates the shared Y SRAM read port.
module ychg_scheduler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // Change-record input
    input  logic        chg_valid,
    output logic        chg_ready,
    input  logic [15:0] chg_row,
    input  logic [15:0] chg_col,
    input  logic [23:0] chg_real,
    input  logic [23:0] chg_img,
    input  logic        chg_last,
    // Update controller/datapath
    output logic        upd_start,
    output logic [15:0] upd_row,
    output logic [15:0] upd_col,
    output logic [23:0] upd_real,
    output logic [23:0] upd_img,
    input  logic        upd_done,
    // Y SRAM read-port arbitration
    input  logic        um_req,
    input  logic [10:0] um_addr,
    output logic        um_gnt,
    input  logic        rd_req,
    input  logic [10:0] rd_addr,
    output logic        rd_gnt,
    output logic        mem_en,
    output logic [10:0] mem_addr,
    // Status
    output logic        busy,
    output logic        list_done,
    output logic        err_timeout,
    output logic [2:0]  fifo_count
);

    localparam int unsigned PtrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  TimeoutVal = 8'(TIMEOUT);
    localparam logic [2:0]  DepthVal   = 3'(DEPTH);

    typedef struct packed {
        logic [15:0] row;
        logic [15:0] col;
        logic [23:0] re;
        logic [23:0] im;
        logic        last;
    } ChgRec;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            stateQ, stateD;
    logic [7:0]        cntQ, cntD;
    logic [2:0]        countQ, countD;
    logic [PtrW-1:0]   wrPtrQ, rdPtrQ;
    ChgRec             fifoMem [DEPTH];
    ChgRec             headRec;
    logic              lastQ;
    logic              listDoneQ;
    logic              errQ;
    logic              prioQ;
    logic              push, pop;
    logic              fifoEmpty;
    logic              doneAccept, timeoutHit;

    assign fifoEmpty = (countQ == 3'd0);
    assign chg_ready = (countQ < DepthVal);
    assign push      = chg_valid & chg_ready;
    assign headRec   = fifoMem[rdPtrQ];

    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        pop        = 1'b0;
        doneAccept = 1'b0;
        timeoutHit = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (!fifoEmpty) begin
                    pop    = 1'b1;
                    stateD = StIssue;
                end
            end
            StIssue: begin
                cntD   = 8'd0;
                stateD = StWait;
            end
            StWait: begin
                cntD = cntQ + 8'd1;
                // A done arriving on the same edge as the limit still completes normally
                if (upd_done) begin
                    doneAccept = 1'b1;
                    if (!fifoEmpty) begin
                        pop    = 1'b1;
                        stateD = StIssue;
                    end else begin
                        stateD = StIdle;
                    end
                end else if (cntD == TimeoutVal) begin
                    timeoutHit = 1'b1;
                    stateD     = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        countD = countQ;
        unique case ({push, pop})
            2'b10:   countD = countQ + 3'd1;
            2'b01:   countD = countQ - 3'd1;
            default: countD = countQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= StIdle;
            cntQ      <= 8'd0;
            countQ    <= 3'd0;
            wrPtrQ    <= '0;
            rdPtrQ    <= '0;
            listDoneQ <= 1'b0;
            errQ      <= 1'b0;
            lastQ     <= 1'b0;
            upd_row   <= 16'd0;
            upd_col   <= 16'd0;
            upd_real  <= 24'd0;
            upd_img   <= 24'd0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            countQ    <= countD;
            listDoneQ <= doneAccept & lastQ;
            errQ      <= errQ | timeoutHit;
            if (push) begin
                wrPtrQ <= wrPtrQ + PtrW'(1);
            end
            if (pop) begin
                rdPtrQ   <= rdPtrQ + PtrW'(1);
                lastQ    <= headRec.last;
                upd_row  <= headRec.row;
                upd_col  <= headRec.col;
                upd_real <= headRec.re;
                upd_img  <= headRec.im;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtrQ] <= '{row: chg_row, col: chg_col, re: chg_real, im: chg_img,
                                 last: chg_last};
        end
    end

    assign upd_start   = (stateQ == StIssue);
    assign busy        = (stateQ != StIdle) | ~fifoEmpty;
    assign list_done   = listDoneQ;
    assign err_timeout = errQ;
    assign fifo_count  = countQ;

    // prio names the side that wins the next contended cycle (0: update engine)
    assign um_gnt   = um_req & (~rd_req | ~prioQ);
    assign rd_gnt   = rd_req & (~um_req | prioQ);
    assign mem_en   = um_gnt | rd_gnt;
    assign mem_addr = um_gnt ? um_addr : (rd_gnt ? rd_addr : 11'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prioQ <= 1'b0;
        end else if (um_req & rd_req) begin
            prioQ <= ~prioQ;
        end
    end

endmodule
